hgcal_fc_manager_counter_bank: RTL

//  Parametrised bank of N_CH event counters for fast-control monitoring, one per fast-command/status line.
//  All channels count in one clock domain. A single strobe snapshots every channel on the same edge.
//  A registered read port returns one snapshot at a time, so software gets a coherent set of counts.

---
 rtl/hgcal_fc_manager_counter_bank.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hgcal_fc_manager_counter_bank.sv
// hgcal_fc_manager_counter_bank
// Bank of N_CH event counters for fast-control monitoring. All live counters
// are latched together by a single snapshot strobe, so the read port always
// presents a coherent set of counts. Each channel has a sticky overflow flag.
// Wrap or saturate is selected at elaboration time. A snapshot can optionally
// restart the live counters. An 8-bit sequence number counts snapshots.
module hgcal_fc_manager_counter_bank #(
  parameter int N_CH          = 8,
  parameter int WIDTH         = 32,
  parameter int SATURATE      = 0,
  parameter int CLEAR_ON_SNAP = 0,
  parameter int ADDR_W        = 6
) (
  input  logic              clk_count,
  input  logic              reset_n,
  input  logic [N_CH-1:0]   ce,
  input  logic              clear,
  input  logic              snapshot,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_ovf,
  output logic [7:0]        snap_seq,
  output logic              snap_done
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  // Live counters and sticky overflow flags
  logic [WIDTH-1:0] cnt [N_CH];
  logic [N_CH-1:0]  ovf;

  // Snapshot registers, captured together on the strobe
  logic [WIDTH-1:0] snap_cnt_p0 [N_CH];
  logic [N_CH-1:0]  snap_ovf_p0;

  // Read-mux result feeding the registered read port
  logic [WIDTH-1:0] rd_mux_data;
  logic             rd_mux_ovf;

  // Next counter value: +1 when enabled, with wrap or saturate at all-ones
  function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] value,
                                                  input logic             en);
    logic [WIDTH-1:0] result;
    result = value;
    if (en) begin
      if (value == CNT_MAX) begin
        result = (SATURATE != 0) ? CNT_MAX : '0;
      end else begin
        result = value + 1'b1;
      end
    end
    return result;
  endfunction

  // Overflow event: an enabled count arriving while the counter is all-ones
  function automatic logic overflow_hit(input logic [WIDTH-1:0] value,
                                        input logic             en);
    return en && (value == CNT_MAX);
  endfunction

  // Live counting; clear wins over everything, then restart-on-snapshot
  always_ff @(posedge clk_count or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
      end
      ovf <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (clear) begin
          cnt[i] <= '0;
          ovf[i] <= 1'b0;
        end else if (snapshot && (CLEAR_ON_SNAP != 0)) begin
          // The event arriving with the strobe belongs to the next interval
          cnt[i] <= {{(WIDTH-1){1'b0}}, ce[i]};
          ovf[i] <= 1'b0;
        end else begin
          cnt[i] <= next_count(cnt[i], ce[i]);
          ovf[i] <= ovf[i] | overflow_hit(cnt[i], ce[i]);
        end
      end
    end
  end

  // Snapshot capture of pre-increment values, sequence count and done pulse
  always_ff @(posedge clk_count or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) begin
        snap_cnt_p0[i] <= '0;
      end
      snap_ovf_p0 <= '0;
      snap_seq    <= '0;
      snap_done   <= 1'b0;
    end else begin
      snap_done <= snapshot;
      if (snapshot) begin
        for (int i = 0; i < N_CH; i++) begin
          snap_cnt_p0[i] <= cnt[i];
        end
        snap_ovf_p0 <= ovf;
        snap_seq    <= snap_seq + 8'd1;
      end
    end
  end

  // Channel select; addresses beyond the bank read as zero
  always_comb begin
    rd_mux_data = '0;
    rd_mux_ovf  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_mux_data = snap_cnt_p0[i];
        rd_mux_ovf  = snap_ovf_p0[i];
      end
    end
  end

  // Registered read port, one cycle behind rd_addr
  always_ff @(posedge clk_count or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
      rd_ovf  <= 1'b0;
    end else begin
      rd_data <= rd_mux_data;
      rd_ovf  <= rd_mux_ovf;
    end
  end

endmodule
